// File: rtl/rv32i_types.sv
// Shared RV32I load/store encodings and LSU helper types.
package rv32i_types;

  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;

  localparam logic [2:0] store_f3_sb = 3'b000;
  localparam logic [2:0] store_f3_sh = 3'b001;
  localparam logic [2:0] store_f3_sw = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Access size in bytes; only meaningful for legal encodings.
  function automatic logic [2:0] lsu_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic lsu_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == store_f3_sb) || (f3 == store_f3_sh) || (f3 == store_f3_sw);
    return (f3 == load_f3_lb) || (f3 == load_f3_lh) || (f3 == load_f3_lw) ||
           (f3 == load_f3_lbu) || (f3 == load_f3_lhu);
  endfunction

endpackage

// File: rtl/lsu_split_if.sv
// Request/response and memory-bus bundle around the load/store unit.
interface lsu_split_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_rmask;
  logic [NB-1:0]     mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  // The LSU itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_rmask, mem_wmask, mem_wdata
  );

  // Core plus memory environment around the LSU.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_rmask, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: beat masks, shifted store data, extended load data.
module lsu_lane_align
  import rv32i_types::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                   funct3_i,
  input  logic [$clog2(DATA_W/8)-1:0]  off_i,
  input  logic [31:0]                  wdata_i,
  input  logic [DATA_W-1:0]            lo_i,
  input  logic [DATA_W-1:0]            hi_i,
  output logic                         split_o,
  output logic [DATA_W/8-1:0]          mask0_o,
  output logic [DATA_W/8-1:0]          mask1_o,
  output logic [DATA_W-1:0]            wdata0_o,
  output logic [DATA_W-1:0]            wdata1_o,
  output logic [31:0]                  rdata_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [2:0]          sz;
  logic [OFF_W+2:0]    bit_off;
  logic [2*NB-1:0]     base_mask;
  logic [2*NB-1:0]     mask_wide;
  logic [31:0]         wtrim;
  logic [2*DATA_W-1:0] wwide;
  logic [31:0]         rwin;

  // Shift everything across a double-width window; upper half belongs to beat 1.
  always_comb begin
    sz      = lsu_size(funct3_i);
    bit_off = {off_i, 3'b000};

    case (sz)
      3'd1:    base_mask = (2*NB)'(4'b0001);
      3'd2:    base_mask = (2*NB)'(4'b0011);
      default: base_mask = (2*NB)'(4'b1111);
    endcase
    mask_wide = base_mask << off_i;

    case (sz)
      3'd1:    wtrim = {24'b0, wdata_i[7:0]};
      3'd2:    wtrim = {16'b0, wdata_i[15:0]};
      default: wtrim = wdata_i;
    endcase
    wwide = {{(2*DATA_W-32){1'b0}}, wtrim} << bit_off;

    rwin = 32'({hi_i, lo_i} >> bit_off);
    case (funct3_i[1:0])
      2'b00:   rdata_o = funct3_i[2] ? {24'b0, rwin[7:0]}  : {{24{rwin[7]}},  rwin[7:0]};
      2'b01:   rdata_o = funct3_i[2] ? {16'b0, rwin[15:0]} : {{16{rwin[15]}}, rwin[15:0]};
      default: rdata_o = rwin;
    endcase
  end

  assign mask0_o  = mask_wide[NB-1:0];
  assign mask1_o  = mask_wide[2*NB-1:NB];
  assign split_o  = |mask1_o;
  assign wdata0_o = wwide[DATA_W-1:0];
  assign wdata1_o = wwide[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/lsu_split.sv
// Load/store unit issuing one or two bus beats per request.
//
//   state | meaning
//   IDLE  | ready for a request, bus quiet
//   BEAT0 | low (or only) beat on the bus, waiting for mem_resp
//   BEAT1 | high beat of a boundary-crossing access, waiting for mem_resp
//   RESP  | one-cycle response pulse
module lsu_split
  import rv32i_types::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  lsu_split_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_BEAT0 = BEAT0;
  localparam logic [1:0] ST_BEAT1 = BEAT1;
  localparam logic [1:0] ST_RESP  = RESP;

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

  logic [1:0]        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [DATA_W-1:0] lo_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              req_fire;
  logic              req_legal;
  logic              beat_done;
  logic [ADDR_W-1:0] beat0_addr;
  logic [ADDR_W-1:0] beat1_addr;
  logic [DATA_W-1:0] lo_in;

  logic              split;
  logic [NB-1:0]     mask0, mask1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [31:0]       load_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_rmask, mem_wmask;
  logic [DATA_W-1:0] mem_wdata;

  assign req_fire   = (state_q == ST_IDLE) && bus.req_valid;
  assign req_legal  = lsu_legal(bus.req_we, bus.req_funct3);
  assign beat_done  = ((state_q == ST_BEAT0) || (state_q == ST_BEAT1)) && bus.mem_resp;
  assign beat0_addr = addr_q & ~LANE_MASK;
  assign beat1_addr = beat0_addr + ADDR_W'(NB);
  // Unsplit loads complete in BEAT0, so the low word comes straight off the bus.
  assign lo_in      = (state_q == ST_BEAT0) ? bus.mem_rdata : lo_q;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[OFF_W-1:0]),
    .wdata_i  (wdata_q),
    .lo_i     (lo_in),
    .hi_i     (bus.mem_rdata),
    .split_o  (split),
    .mask0_o  (mask0),
    .mask1_o  (mask1),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1),
    .rdata_o  (load_data)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req_valid) state_d = req_legal ? ST_BEAT0 : ST_RESP;
      ST_BEAT0: if (bus.mem_resp)  state_d = split ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (bus.mem_resp)  state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, request latch, low-beat capture and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        if (!req_legal) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if ((state_q == ST_BEAT0) && bus.mem_resp)
        lo_q <= bus.mem_rdata;
      if (beat_done && (state_d == ST_RESP)) begin
        rdata_q <= we_q ? '0 : load_data;
        err_q   <= 1'b0;
      end
    end
  end

  // Bus drive is a pure function of state, so reset silences it immediately.
  always_comb begin
    mem_addr  = '0;
    mem_rmask = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (state_q == ST_BEAT0) begin
      mem_addr  = beat0_addr;
      mem_rmask = we_q ? '0 : mask0;
      mem_wmask = we_q ? mask0 : '0;
      mem_wdata = we_q ? wdata0 : '0;
    end else if (state_q == ST_BEAT1) begin
      mem_addr  = beat1_addr;
      mem_rmask = we_q ? '0 : mask1;
      mem_wmask = we_q ? mask1 : '0;
      mem_wdata = we_q ? wdata1 : '0;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_rmask = mem_rmask;
  assign bus.mem_wmask = mem_wmask;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_lsu_split.sv
// Directed plus random requests against a byte-addressed memory model.
module tb_lsu_split;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_split_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  lsu_split    #(.DATA_W(32), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  bit [7:0] mem [bit [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] mem_get(input bit [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic bit [31:0] mem_word(input bit [31:0] base);
    bit [31:0] w;
    for (int l = 0; l < 4; l++) w[8*l +: 8] = mem_get(base + 32'(l));
    return w;
  endfunction

  // One request from accept to return-to-idle; every bus cycle is checked.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, input int waits,
                        output bit [31:0] got, output bit got_err);
    int        sz, nbeats, idx, lane;
    bit        ok;
    bit [31:0] a, exp_r;
    bit [31:0] baddr [2];
    bit [3:0]  mask  [2];
    bit [31:0] wexp  [2];

    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    baddr[0] = addr & ~32'd3;
    baddr[1] = baddr[0] + 32'd4;
    mask[0] = '0; mask[1] = '0; wexp[0] = '0; wexp[1] = '0;
    exp_r = '0;
    if (ok) begin
      for (int i = 0; i < sz; i++) begin
        a    = addr + 32'(i);
        idx  = ((a & ~32'd3) != baddr[0]) ? 1 : 0;
        lane = int'(a[1:0]);
        mask[idx][lane] = 1'b1;
        wexp[idx][8*lane +: 8] = wd[8*i +: 8];
        if (!we) exp_r[8*i +: 8] = mem_get(a);
      end
      if (!we && !f3[2] && sz == 1) exp_r = {{24{exp_r[7]}}, exp_r[7:0]};
      if (!we && !f3[2] && sz == 2) exp_r = {{16{exp_r[15]}}, exp_r[15:0]};
    end
    nbeats = !ok ? 0 : (mask[1] != 0) ? 2 : 1;

    chk("ready_before_req", bus.req_ready, 1'b1);
    bus.mem_resp   = 1'($urandom_range(0, 1));
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;

    for (int b = 0; b < nbeats; b++) begin
      for (int w = 0; w <= waits; w++) begin
        chk("beat_addr",  bus.mem_addr,  baddr[b]);
        chk("beat_rmask", bus.mem_rmask, we ? 4'b0 : mask[b]);
        chk("beat_wmask", bus.mem_wmask, we ? mask[b] : 4'b0);
        chk("beat_wdata", bus.mem_wdata, we ? wexp[b] : 32'b0);
        chk("beat_rsp_valid", bus.rsp_valid, 1'b0);
        chk("beat_ready", bus.req_ready, 1'b0);
        if (w == waits) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = mem_word(baddr[b]);
        end else begin
          bus.mem_resp  = 1'b0;
          bus.mem_rdata = $urandom;
        end
        @(negedge clk);
      end
    end

    bus.mem_resp  = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_err",   bus.rsp_err, !ok);
    chk("rsp_rdata", bus.rsp_rdata, exp_r);
    chk("rsp_masks", {bus.mem_rmask, bus.mem_wmask}, 8'b0);
    chk("rsp_ready", bus.req_ready, 1'b0);
    got     = bus.rsp_rdata;
    got_err = bus.rsp_err;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    chk("after_rsp_valid", bus.rsp_valid, 1'b0);
    chk("after_rsp_ready", bus.req_ready, 1'b1);
    chk("after_rsp_hold",  bus.rsp_rdata, exp_r);
    chk("after_rsp_masks", {bus.mem_rmask, bus.mem_wmask}, 8'b0);

    if (ok && we)
      for (int i = 0; i < sz; i++) mem[addr + 32'(i)] = wd[8*i +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit [31:0] got;
    bit        gerr;
    bit [31:0] raddr;

    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.mem_rdata = 0; bus.mem_resp = 0;

    // Reset values
    #12;
    chk("rst_ready",     bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'b0);
    chk("rst_rsp_err",   bus.rsp_err, 1'b0);
    chk("rst_mem_addr",  bus.mem_addr, 32'b0);
    chk("rst_rmask",     bus.mem_rmask, 4'b0);
    chk("rst_wmask",     bus.mem_wmask, 4'b0);
    chk("rst_wdata",     bus.mem_wdata, 32'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LW aligned
    mem[32'h1000] = 8'hEF; mem[32'h1001] = 8'hBE; mem[32'h1002] = 8'hAD; mem[32'h1003] = 8'hDE;
    do_req(1'b0, 3'd2, 32'h1000, 32'h0, 0, got, gerr);
    chk("lw_value", got, 32'hDEADBEEF);

    // LH split across 0x1003/0x1004
    mem[32'h1000] = 8'h00; mem[32'h1001] = 8'h00; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h80;
    mem[32'h1004] = 8'hFF; mem[32'h1005] = 8'h00; mem[32'h1006] = 8'h00; mem[32'h1007] = 8'h00;
    do_req(1'b0, 3'd1, 32'h1003, 32'h0, 0, got, gerr);
    chk("lh_split_value", got, 32'hFFFFFF80);

    // SW split
    do_req(1'b1, 3'd2, 32'h2002, 32'h11223344, 0, got, gerr);
    chk("sw_rdata_zero", got, 32'h0);

    // LBU / LB with wait states
    mem[32'h3000] = 8'h00; mem[32'h3001] = 8'hAB; mem[32'h3002] = 8'h00; mem[32'h3003] = 8'h00;
    do_req(1'b0, 3'd4, 32'h3001, 32'h0, 3, got, gerr);
    chk("lbu_value", got, 32'h000000AB);
    do_req(1'b0, 3'd0, 32'h3001, 32'h0, 3, got, gerr);
    chk("lb_value", got, 32'hFFFFFFAB);

    // SH wrapping past the top of the address space
    do_req(1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000BEEF, 1, got, gerr);
    do_req(1'b0, 3'd5, 32'hFFFFFFFF, 32'h0, 0, got, gerr);
    chk("lhu_wrap_readback", got, 32'h0000BEEF);

    // Illegal encodings
    do_req(1'b0, 3'd3, 32'h4000, 32'h0, 0, got, gerr);
    chk("illegal_load_err", gerr, 1'b1);
    do_req(1'b1, 3'd5, 32'h4001, 32'h12345678, 0, got, gerr);
    chk("illegal_store_err", gerr, 1'b1);

    // Reset asserted while the high beat is outstanding
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd1; bus.req_addr = 32'h1003;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_rst_beat0_rmask", bus.mem_rmask, 4'b1000);
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h80000000;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    chk("mid_rst_beat1_rmask", bus.mem_rmask, 4'b0001);
    chk("mid_rst_beat1_addr",  bus.mem_addr, 32'h1004);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rmask", bus.mem_rmask, 4'b0);
    chk("mid_rst_addr",  bus.mem_addr, 32'h0);
    chk("mid_rst_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("post_rst_ready", bus.req_ready, 1'b1);
      @(negedge clk);
    end

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      raddr = ($urandom_range(0, 1) == 0) ? (32'h5000 + 32'($urandom_range(0, 15)))
                                          : (32'hFFFFFFF0 + 32'($urandom_range(0, 15)));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), raddr, $urandom,
             $urandom_range(0, 3), got, gerr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
